// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared constants, types and helpers for the pipeline hazard
//                controller: FSM state encoding, MEM_TIMEOUT default,
//                counter widths, control-bundle type and load-use detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Default limit on consecutive MEM_WAIT cycles (legal 1..255)
    localparam int unsigned MEM_TIMEOUT_DEF = 255;

    // Counter widths
    localparam int unsigned WAIT_CNT_W = 8;
    localparam int unsigned PERF_CNT_W = 32;

    // FSM encoding; 2'b11 is unused and recovers to RUN
    localparam int unsigned STATE_W     = 2;
    localparam logic [1:0]  ST_RUN      = 2'b00;
    localparam logic [1:0]  ST_MEM_WAIT = 2'b01;
    localparam logic [1:0]  ST_ERR      = 2'b10;

    // Pipeline control bundle driven by the controller every cycle
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic pipe_hold;
    } haz_ctrl_t;

    // Normal flow: everything advances, nothing flushed
    localparam haz_ctrl_t CTRL_FLOW = '{pc_write: 1'b1, ifid_write: 1'b1,
                                        ifid_flush: 1'b0, idex_flush: 1'b0,
                                        pipe_hold: 1'b0};

    // Whole pipeline frozen (memory stall or error)
    localparam haz_ctrl_t CTRL_HOLD = '{pc_write: 1'b0, ifid_write: 1'b0,
                                        ifid_flush: 1'b0, idex_flush: 1'b0,
                                        pipe_hold: 1'b1};

    // Taken branch: squash the two younger slots, fetch from the target
    localparam haz_ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, ifid_write: 1'b1,
                                          ifid_flush: 1'b1, idex_flush: 1'b1,
                                          pipe_hold: 1'b0};

    // Load-use: freeze front end, inject one bubble into ID/EX
    localparam haz_ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, ifid_write: 1'b0,
                                            ifid_flush: 1'b0, idex_flush: 1'b1,
                                            pipe_hold: 1'b0};

    // A load in EX whose destination feeds the instruction in ID.
    // Register 0 is hardwired zero and never creates a dependency.
    function automatic logic load_use_hit(
        input logic       mem_read_ex,
        input logic [4:0] rt_ex,
        input logic [4:0] rs_id,
        input logic [4:0] rt_id
    );
        return mem_read_ex && (rt_ex != 5'd0) &&
               ((rt_ex == rs_id) || (rt_ex == rt_id));
    endfunction

endpackage
`default_nettype wire

// File: rtl/haz_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : haz_wait_timer
//  Description : Counts consecutive data-memory wait cycles. Supports load
//                (start of a wait at 1), increment, clear, and flags when the
//                count has reached MEM_TIMEOUT. Saturates, never wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module haz_wait_timer
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic inc,
    input  logic clr,
    output logic timeout
);

    localparam logic [WAIT_CNT_W-1:0] c_limit = MEM_TIMEOUT[WAIT_CNT_W-1:0];

    logic [WAIT_CNT_W-1:0] r_wait_cnt;

    // Wait counter: clear wins over load, load over increment; holds at limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (clr) begin
            r_wait_cnt <= '0;
        end else if (load) begin
            r_wait_cnt <= {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end else if (inc && (r_wait_cnt != c_limit)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign timeout = (r_wait_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Hazard controller for a 5-stage pipeline. Resolves memory
//                stalls (with timeout to an error state), taken-branch
//                flushes and load-use bubbles. Outputs are Mealy.
//                Optional build macro HAZ_PERF_CNT_EN adds stall_cnt and
//                flush_cnt performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         Rs_ID,
    input  logic [4:0]         Rt_ID,
    input  logic [4:0]         Rt_EX,
    input  logic               MemRead_EX,
    input  logic               Branch_taken_EX,
    input  logic               dmem_req_MEM,
    input  logic               dmem_ready,
    input  logic               err_clr,
    output logic               PC_Write,
    output logic               IFID_Write,
    output logic               IFID_Flush,
    output logic               IDEX_Flush,
    output logic               Pipe_Hold,
    output logic               mem_err,
    output logic [STATE_W-1:0] ctrl_state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    haz_ctrl_t          w_ctrl;
    logic               r_mem_err;
    logic               w_set_err;
    logic               w_clr_err;
    logic               w_tmr_load;
    logic               w_tmr_inc;
    logic               w_tmr_clr;
    logic               w_timeout;
    logic               w_mem_stall;
    logic               w_load_use;

    assign w_mem_stall = dmem_req_MEM && !dmem_ready;
    assign w_load_use  = load_use_hit(MemRead_EX, Rt_EX, Rs_ID, Rt_ID);

    haz_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_tmr_load),
        .inc     (w_tmr_inc),
        .clr     (w_tmr_clr),
        .timeout (w_timeout)
    );

    // Next-state and Mealy control decode. While the pipeline is held the
    // branch/load-use inputs stay stable upstream, so they are simply not
    // acted on until the hold releases and are decoded then.
    always_comb begin
        w_next_state = r_state;
        w_ctrl       = CTRL_FLOW;
        w_tmr_load   = 1'b0;
        w_tmr_inc    = 1'b0;
        w_tmr_clr    = 1'b0;
        w_set_err    = 1'b0;
        w_clr_err    = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_mem_stall) begin
                    w_ctrl       = CTRL_HOLD;
                    w_next_state = ST_MEM_WAIT;
                    w_tmr_load   = 1'b1;
                end else if (Branch_taken_EX) begin
                    w_ctrl = CTRL_BRANCH;
                end else if (w_load_use) begin
                    w_ctrl = CTRL_LOAD_USE;
                end
            end

            ST_MEM_WAIT: begin
                if (!dmem_ready) begin
                    w_ctrl = CTRL_HOLD;
                    if (w_timeout) begin
                        w_next_state = ST_ERR;
                        w_set_err    = 1'b1;
                        w_tmr_clr    = 1'b1;
                    end else begin
                        w_tmr_inc = 1'b1;
                    end
                end else begin
                    // Release cycle: deferred hazards take effect now
                    w_next_state = ST_RUN;
                    w_tmr_clr    = 1'b1;
                    if (Branch_taken_EX) begin
                        w_ctrl = CTRL_BRANCH;
                    end else if (w_load_use) begin
                        w_ctrl = CTRL_LOAD_USE;
                    end
                end
            end

            ST_ERR: begin
                w_ctrl = CTRL_HOLD;
                if (err_clr) begin
                    w_next_state = ST_RUN;
                    w_clr_err    = 1'b1;
                end
            end

            default: begin
                w_next_state = ST_RUN;
                w_tmr_clr    = 1'b1;
            end
        endcase

        // Reset drives the pipeline to free-flowing regardless of inputs
        if (!rst_n) begin
            w_ctrl = CTRL_FLOW;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Sticky memory-timeout flag, cleared only by err_clr while in ERR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_err <= 1'b0;
        end else if (w_set_err) begin
            r_mem_err <= 1'b1;
        end else if (w_clr_err) begin
            r_mem_err <= 1'b0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] r_stall_cnt;
    logic [PERF_CNT_W-1:0] r_flush_cnt;

    // Performance counters: stalled-fetch cycles and branch-flush cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_ctrl.pc_write) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_ctrl.ifid_flush) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

    assign PC_Write   = w_ctrl.pc_write;
    assign IFID_Write = w_ctrl.ifid_write;
    assign IFID_Flush = w_ctrl.ifid_flush;
    assign IDEX_Flush = w_ctrl.idex_flush;
    assign Pipe_Hold  = w_ctrl.pipe_hold;
    assign mem_err    = r_mem_err;
    assign ctrl_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Directed self-checking bench for pipeline_hazard_ctrl with
//                MEM_TIMEOUT=4. Expected control vectors are queued when
//                stimulus is applied and compared when outputs are sampled.
//                Honours HAZ_PERF_CNT_EN for the optional counter ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] Rs_ID, Rt_ID, Rt_EX;
    logic       MemRead_EX, Branch_taken_EX, dmem_req_MEM, dmem_ready, err_clr;
    logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Hold, mem_err;
    logic [1:0] ctrl_state;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .Rs_ID           (Rs_ID),
        .Rt_ID           (Rt_ID),
        .Rt_EX           (Rt_EX),
        .MemRead_EX      (MemRead_EX),
        .Branch_taken_EX (Branch_taken_EX),
        .dmem_req_MEM    (dmem_req_MEM),
        .dmem_ready      (dmem_ready),
        .err_clr         (err_clr),
        .PC_Write        (PC_Write),
        .IFID_Write      (IFID_Write),
        .IFID_Flush      (IFID_Flush),
        .IDEX_Flush      (IDEX_Flush),
        .Pipe_Hold       (Pipe_Hold),
        .mem_err         (mem_err),
        .ctrl_state      (ctrl_state)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector layout: {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush,
    //                          Pipe_Hold, mem_err, ctrl_state[1:0]}
    function automatic logic [7:0] flow(input logic [1:0] st, input logic err);
        return {5'b11000, err, st};
    endfunction
    function automatic logic [7:0] hold(input logic [1:0] st, input logic err);
        return {5'b00001, err, st};
    endfunction
    function automatic logic [7:0] stall(input logic [1:0] st);
        return {5'b00010, 1'b0, st};
    endfunction
    function automatic logic [7:0] flush(input logic [1:0] st);
        return {5'b11110, 1'b0, st};
    endfunction

    function automatic logic [7:0] observed();
        return {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Hold,
                mem_err, ctrl_state};
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rtex, input logic memrd,
                         input logic br, input logic req, input logic rdy,
                         input logic clr);
        Rs_ID = rs; Rt_ID = rt; Rt_EX = rtex; MemRead_EX = memrd;
        Branch_taken_EX = br; dmem_req_MEM = req; dmem_ready = rdy;
        err_clr = clr;
    endtask

    // Pop the oldest expectation and compare against the live outputs
    task automatic check_now(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            cmp({tag, "_noexp"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            cmp(tag, {24'd0, observed()}, {24'd0, e});
        end
    endtask

    // One cycle: inputs already applied just after the rising edge;
    // sample on the falling edge, then advance past the next rising edge.
    task automatic step(input string tag, input logic [7:0] e);
        exp_q.push_back(e);
        @(negedge clk);
        check_now(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with hazards present on the inputs
        rst_n = 1'b0;
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        #3;
        exp_q.push_back(flow(2'b00, 1'b0));
        check_now("reset_out");
        @(posedge clk); #1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        step("idle", flow(2'b00, 1'b0));

        // Load-use on Rs, then one bubble only
        drive(5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_rs", stall(2'b00));
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_gap", flow(2'b00, 1'b0));

        // Rt_EX = 0 never stalls
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_r0", flow(2'b00, 1'b0));

        // Branch wins over load-use
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("br_lu", flush(2'b00));
`ifdef HAZ_PERF_CNT_EN
        cmp("stall_cnt", stall_cnt, 32'd1);
        cmp("flush_cnt", flush_cnt, 32'd1);
`endif

        // Load-use via Rt match; unrelated load; lone branch
        drive(5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_rt", stall(2'b00));
        drive(5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_miss", flow(2'b00, 1'b0));
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("br_only", flush(2'b00));

        // Memory wait: ready low three cycles then high
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("mw_1", hold(2'b00, 1'b0));
        step("mw_2", hold(2'b01, 1'b0));
        step("mw_3", hold(2'b01, 1'b0));
        dmem_ready = 1'b1;
        step("mw_rdy", flow(2'b01, 1'b0));
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("mw_back", flow(2'b00, 1'b0));

        // Branch during hold is deferred to the release cycle
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("brh_hold", hold(2'b00, 1'b0));
        dmem_ready = 1'b1;
        step("brh_rel", flush(2'b01));

        // Load-use during hold is deferred to the release cycle
        drive(5'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("luh_hold", hold(2'b00, 1'b0));
        dmem_ready = 1'b1;
        step("luh_rel", stall(2'b01));
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("luh_back", flow(2'b00, 1'b0));

        // err_clr outside ERR is ignored
        err_clr = 1'b1;
        step("clr_run", flow(2'b00, 1'b0));
        err_clr = 1'b0;

        // Timeout: RUN entry plus four MEM_WAIT cycles, then ERR
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("to_0", hold(2'b00, 1'b0));
        for (int i = 1; i <= 4; i++) begin
            step($sformatf("to_w%0d", i), hold(2'b01, 1'b0));
        end
        step("to_err", hold(2'b10, 1'b1));
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("to_stay", hold(2'b10, 1'b1));
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("to_clr", hold(2'b10, 1'b1));
        err_clr = 1'b0;
        step("to_run", flow(2'b00, 1'b0));

        // Async reset between edges while in MEM_WAIT
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("ar_1", hold(2'b00, 1'b0));
        step("ar_2", hold(2'b01, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(flow(2'b00, 1'b0));
        check_now("ar_async");
        @(posedge clk); #1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step("ar_after", flow(2'b00, 1'b0));
        // A fresh wait starts from scratch: full timeout still needed
        dmem_req_MEM = 1'b1;
        step("ar_w0", hold(2'b00, 1'b0));
        for (int i = 1; i <= 4; i++) begin
            step($sformatf("ar_w%0d", i), hold(2'b01, 1'b0));
        end
        step("ar_err", hold(2'b10, 1'b1));

        if (exp_q.size() != 0) begin
            cmp("queue_drain", exp_q.size(), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255, max consecutive MEM_WAIT cycles before error; legal range 1..255.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Rs_ID, Rt_ID  in  5 each  source registers of instruction in IF/ID.
REQ-005 Rt_EX  in  5  destination of instruction in ID/EX; MemRead_EX  in  1  that instruction is a load.
REQ-006 Branch_taken_EX  in  1  branch/jump resolved taken in EX this cycle.
REQ-007 dmem_req_MEM  in  1  MEM-stage access active; dmem_ready  in  1  data memory completes access this cycle.
REQ-008 err_clr  in  1  clears error state.
REQ-009 PC_Write, IFID_Write  out  1 each  enable PC / IF/ID update.
REQ-010 IFID_Flush, IDEX_Flush  out  1 each  load bubble into IF/ID / ID/EX.
REQ-011 Pipe_Hold  out  1  freeze ID/EX, EX/MEM, MEM/WB registers.
REQ-012 mem_err  out  1  memory-timeout error flag; ctrl_state  out  2  current FSM state.

Function
REQ-013 FSM states: RUN=2'b00, MEM_WAIT=2'b01, ERR=2'b10; 2'b11 SHALL go to RUN.
REQ-014 Outputs Mealy (state + inputs); defaults PC_Write=1, IFID_Write=1, flushes=0, Pipe_Hold=0.
REQ-015 RUN, priority 1: dmem_req_MEM && !dmem_ready -> Pipe_Hold=1, PC_Write=0, IFID_Write=0, flushes=0; next MEM_WAIT, wait_cnt<=1.
REQ-016 RUN, priority 2: Branch_taken_EX -> IFID_Flush=1, IDEX_Flush=1, PC_Write=1, IFID_Write=1; exactly two flushed slots.
REQ-017 RUN, priority 3: load-use = MemRead_EX && Rt_EX!=0 && (Rt_EX==Rs_ID || Rt_EX==Rt_ID) -> PC_Write=0, IFID_Write=0, IDEX_Flush=1; exactly one bubble, stays RUN.
REQ-018 MEM_WAIT, dmem_ready=0: hold outputs per REQ-015; wait_cnt increments; wait_cnt==MEM_TIMEOUT -> next ERR, mem_err<=1.
REQ-019 MEM_WAIT, dmem_ready=1: Pipe_Hold=0 same cycle; REQ-016/017 evaluated as in RUN; next RUN, wait_cnt<=0.
REQ-020 Branch or load-use coincident with a hold SHALL be suppressed, not lost: inputs remain stable while held and are re-evaluated on release.
REQ-021 ERR: Pipe_Hold=1, PC_Write=0, IFID_Write=0, flushes=0; err_clr=1 -> next RUN, mem_err<=0; otherwise stay.
REQ-022 err_clr outside ERR SHALL have no effect.
REQ-023 wait_cnt 8 bits, never wraps (bounded by MEM_TIMEOUT).

Reset
REQ-024 rst_n=0 SHALL immediately force RUN, wait_cnt=0, mem_err=0, independent of clk.
REQ-025 During reset, outputs: PC_Write=1, IFID_Write=1, flushes=0, Pipe_Hold=0, ctrl_state=00.
REQ-026 Reset asserted mid-MEM_WAIT or in ERR SHALL abandon the wait with no residual state.

Configuration
REQ-027 Macro HAZ_PERF_CNT_EN: when defined, adds outputs stall_cnt[31:0] (increments each cycle PC_Write=0) and flush_cnt[31:0] (increments each cycle IFID_Flush=1), both reset 0, wrap mod 2^32.
REQ-028 Without HAZ_PERF_CNT_EN: ports and counters absent; all other behaviour identical.

Structure
REQ-029 Shared package hazard_pkg: state encoding constants, MEM_TIMEOUT default, counter widths.
REQ-030 Sub-module haz_wait_timer: wait_cnt, load/increment/clear, timeout compare output.

Verification
REQ-031 Load-use: MemRead_EX=1, Rt_EX=5, Rs_ID=5 -> one cycle PC_Write=0, IFID_Write=0, IDEX_Flush=1; Rt_EX=0 -> no stall.
REQ-032 Branch + load-use same cycle: Branch_taken_EX=1 -> IFID_Flush=IDEX_Flush=1, PC_Write=1.
REQ-033 Mem wait: dmem_req_MEM=1, dmem_ready low 3 cycles then high -> Pipe_Hold=1 for 3 cycles, 0 on ready cycle, ctrl_state 01->00.
REQ-034 Timeout: MEM_TIMEOUT=4, ready never -> ERR after 4 wait cycles, mem_err=1; err_clr pulse -> RUN, mem_err=0.
REQ-035 Async reset asserted between edges during MEM_WAIT -> ctrl_state=00, Pipe_Hold=0 before next edge.
REQ-036 With HAZ_PERF_CNT_EN: REQ-031 plus REQ-032 sequence -> stall_cnt=1, flush_cnt=1.
